// File: rtl/top_multiplier.sv
// top_multiplier
//   Sequential unsigned shift-and-add multiplier, p = ain * pin.
//   A level-sensitive go starts an operation from IDLE. One multiplier bit is
//   processed per clock, and done then holds until go is released.
//
// Ports
//   clk   in   1        rising-edge clock
//   rst   in   1        synchronous active-high reset, aborts any operation
//   go    in   1        start request (level); ignored outside IDLE
//   ain   in   WIDTH    multiplicand, captured on the start edge
//   pin   in   WIDTH    multiplier, captured on the start edge
//   done  out  1        result valid (registered, high while in DONE)
//   p     out  2*WIDTH  product (registered, changes only on completion/reset)
module top_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   pin,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] p_reg;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      cnt;
    logic               last;

    // cnt counts completed steps. The edge after the WIDTH-th step commits
    // the product, so done rises WIDTH+1 edges after the start edge.
    assign last = (cnt == CW'(WIDTH));

    always_comb begin
        addend = '0;
        if (b_reg[0])
            addend = {{WIDTH{1'b0}}, a_reg} << cnt;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go)   state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (!go)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            p_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        a_reg <= ain;
                        b_reg <= pin;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (last) begin
                        p_reg <= acc;
                    end else begin
                        acc   <= acc + addend;
                        b_reg <= b_reg >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: both are taken directly from flops.
    always_comb begin
        done = (state == DONE);
        p    = p_reg;
    end

endmodule

// File: tb/tb_top_multiplier.sv
// tb_top_multiplier
//   Directed self-checking bench for top_multiplier (WIDTH = 8).
module tb_top_multiplier;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               go;
    logic [WIDTH-1:0]   ain;
    logic [WIDTH-1:0]   pin;
    logic               done;
    logic [2*WIDTH-1:0] p;

    int unsigned total;
    int unsigned passed;

    top_multiplier #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .ain  (ain),
        .pin  (pin),
        .done (done),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Full operation: start edge, 8 stepping edges with done low and p held,
    // 9th edge completes, then go drops for one edge to return to IDLE.
    task automatic mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [31:0] exp, input logic [31:0] prev, input string tag);
        ain = a;
        pin = b;
        go  = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check({tag, " done low"}, {31'd0, done}, 32'd0);
            check({tag, " p held"}, {16'd0, p}, prev);
        end
        tick();
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " p"}, {16'd0, p}, exp);
        go = 1'b0;
        tick();
        check({tag, " done drop"}, {31'd0, done}, 32'd0);
        check({tag, " p kept"}, {16'd0, p}, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        go     = 1'b0;
        ain    = '0;
        pin    = '0;
        tick();
        tick();
        check("reset done", {31'd0, done}, 32'd0);
        check("reset p", {16'd0, p}, 32'd0);
        rst = 1'b0;

        // 2*2 with go held through DONE
        ain = 8'd2;
        pin = 8'd2;
        go  = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1 done low", {31'd0, done}, 32'd0);
        end
        tick();
        check("t1 done", {31'd0, done}, 32'd1);
        check("t1 p", {16'd0, p}, 32'd4);
        tick();
        tick();
        check("t1 done held", {31'd0, done}, 32'd1);
        check("t1 p held", {16'd0, p}, 32'd4);
        go = 1'b0;
        tick();
        check("t1 done drop", {31'd0, done}, 32'd0);
        check("t1 p kept", {16'd0, p}, 32'd4);

        // Boundaries
        mult(8'd255, 8'd255, 32'd65025, 32'd4, "t2 255x255");
        mult(8'd0, 8'd173, 32'd0, 32'd65025, "t3 0x173");
        mult(8'd173, 8'd0, 32'd0, 32'd0, "t3 173x0");
        mult(8'd128, 8'd255, 32'd32640, 32'd0, "t3 128x255");

        // Inputs changed during RUN are ignored
        ain = 8'd3;
        pin = 8'd5;
        go  = 1'b1;
        tick();
        ain = 8'd7;
        pin = 8'd9;
        for (int i = 0; i < 8; i++) tick();
        check("t4 done low", {31'd0, done}, 32'd0);
        tick();
        check("t4 done", {31'd0, done}, 32'd1);
        check("t4 p", {16'd0, p}, 32'd15);
        go = 1'b0;
        tick();
        check("t4 done drop", {31'd0, done}, 32'd0);

        // Back-to-back with one low-go edge between
        mult(8'd6, 8'd7, 32'd42, 32'd15, "t5 6x7");
        mult(8'd10, 8'd10, 32'd100, 32'd42, "t5 10x10");

        // Reset on the 4th RUN edge aborts the operation
        ain = 8'd11;
        pin = 8'd13;
        go  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        go  = 1'b0;
        check("t6 rst done", {31'd0, done}, 32'd0);
        check("t6 rst p", {16'd0, p}, 32'd0);
        tick();
        check("t6 idle done", {31'd0, done}, 32'd0);
        mult(8'd11, 8'd13, 32'd143, 32'd0, "t6 restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
